// File: rtl/bnn_infer_ctrl.sv
// Sequencer in front of the combinational BNN_network: streams the image into
// the network input register, waits for the datapath to settle, then hands out the class.
module bnn_infer_ctrl #(
    parameter int  IMG_SIZE      = 30,
    parameter int  IN_WIDTH      = 8,
    parameter int  NUM_CLASS     = 10,
    parameter int  SETTLE_CYCLES = 4,
    localparam int IMG_BITS      = IMG_SIZE * IMG_SIZE,
    localparam int CLS_W         = $clog2(NUM_CLASS),
    localparam int NUM_BEATS     = (IMG_BITS + IN_WIDTH - 1) / IN_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic [IN_WIDTH-1:0] in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [IMG_BITS-1:0] img_out_o,
    input  logic [CLS_W-1:0]    net_class_i,
    output logic [CLS_W-1:0]    class_out_o,
    output logic                class_err_o,
    output logic                class_valid_o,
    input  logic                class_ready_i,
    output logic                busy_o,
    output logic [7:0]          infer_cnt_o
);

    // state  | meaning
    // LOAD   | accepting image beats into the image register
    // SETTLE | image stable, counting down while the network resolves
    // RESULT | class index held until the consumer takes it
    typedef enum logic [1:0] {
        S_LOAD,
        S_SETTLE,
        S_RESULT
    } state_t;

    localparam int                 BEAT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [BEAT_W-1:0]  LAST_BEAT   = BEAT_W'(NUM_BEATS - 1);
    localparam logic [7:0]         SETTLE_INIT = 8'(SETTLE_CYCLES - 1);
    localparam logic [CLS_W:0]     CLASS_LIM   = (CLS_W + 1)'(NUM_CLASS);

    state_t              state_q;
    logic [BEAT_W-1:0]   beat_cnt_q;
    logic [7:0]          settle_cnt_q;
    logic [IMG_BITS-1:0] img_q;
    logic [IMG_BITS-1:0] img_d;
    logic [CLS_W-1:0]    class_q;
    logic                class_err_q;
    logic [7:0]          infer_cnt_q;

    // Bits past IMG_BITS in the final beat simply have no destination.
    always_comb begin
        img_d = img_q;
        for (int k = 0; k < IMG_BITS; k++) begin
            if (beat_cnt_q == BEAT_W'(k / IN_WIDTH)) begin
                img_d[k] = in_data_i[k % IN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_LOAD;
            beat_cnt_q   <= '0;
            settle_cnt_q <= '0;
            img_q        <= '0;
            class_q      <= '0;
            class_err_q  <= 1'b0;
            infer_cnt_q  <= '0;
        end else if (flush_i) begin
            state_q      <= S_LOAD;
            beat_cnt_q   <= '0;
            settle_cnt_q <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid_i) begin
                        img_q <= img_d;
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_q   <= '0;
                            settle_cnt_q <= SETTLE_INIT;
                            state_q      <= S_SETTLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_q != '0) begin
                        settle_cnt_q <= settle_cnt_q - 1'b1;
                    end else begin
                        class_q     <= net_class_i;
                        class_err_q <= ({1'b0, net_class_i} >= CLASS_LIM);
                        infer_cnt_q <= infer_cnt_q + 8'd1;
                        state_q     <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (class_ready_i) begin
                        state_q <= S_LOAD;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign in_ready_o    = (state_q == S_LOAD);
    assign busy_o        = (state_q == S_SETTLE) || (state_q == S_RESULT);
    assign class_valid_o = (state_q == S_RESULT);
    assign img_out_o     = img_q;
    assign class_out_o   = class_q;
    assign class_err_o   = class_err_q;
    assign infer_cnt_o   = infer_cnt_q;

endmodule

// File: tb/tb_bnn_infer_ctrl.sv
// Directed bench for bnn_infer_ctrl: image loading, settle latency, backpressure,
// flush, class error flag, counter wrap and reset.
module tb_bnn_infer_ctrl;

    localparam int IMG_BITS  = 900;
    localparam int NUM_BEATS = 113;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [899:0] img_out;
    logic [3:0]   net_class;
    logic [3:0]   class_out;
    logic         class_err;
    logic         class_valid;
    logic         class_ready;
    logic         busy;
    logic [7:0]   infer_cnt;

    logic [899:0] exp_img;
    int           n_chk  = 0;
    int           n_fail = 0;

    bnn_infer_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .img_out_o    (img_out),
        .net_class_i  (net_class),
        .class_out_o  (class_out),
        .class_err_o  (class_err),
        .class_valid_o(class_valid),
        .class_ready_i(class_ready),
        .busy_o       (busy),
        .infer_cnt_o  (infer_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d fails=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_img(input string tag);
        int first;
        n_chk++;
        assert (img_out === exp_img) else begin
            n_fail++;
            first = -1;
            for (int k = 0; k < IMG_BITS; k++)
                if (first < 0 && img_out[k] !== exp_img[k]) first = k;
            $error("FAIL %s: img_out bit %0d observed %b expected %b", tag, first,
                   img_out[first], exp_img[first]);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_chk++;
        n_fail++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    task automatic send_beat(input int k, input logic [7:0] d, input bit gaps);
        bit acc;
        int budget;
        if (gaps && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            step();
        end
        in_valid = 1'b1;
        in_data  = d;
        budget   = 0;
        acc      = 1'b0;
        while (!acc) begin
            acc = in_ready;
            step();
            budget++;
            if (!acc && budget > 50) begin
                timeout_fail("beat_accept");
                break;
            end
        end
        if (acc)
            for (int i = 0; i < 8; i++)
                if (k * 8 + i < IMG_BITS) exp_img[k * 8 + i] = d[i];
    endtask

    // mode 0: constant fill, mode 1: beat index as data
    task automatic send_image(input int first, input int mode, input logic [7:0] fill, input bit gaps);
        for (int k = first; k < NUM_BEATS; k++)
            send_beat(k, (mode == 1) ? 8'(k) : fill, gaps);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (class_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (class_valid !== 1'b1) timeout_fail(tag);
    endtask

    task automatic release_result();
        class_ready = 1'b1;
        step();
        class_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0;
        net_class = 4'd7; class_ready = 1'b0;
        exp_img = '0;
        step();
        step();
        rst = 1'b0;

        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_class_valid", 32'(class_valid), 0);
        chk("rst_class_out", 32'(class_out), 0);
        chk("rst_class_err", 32'(class_err), 0);
        chk("rst_infer_cnt", 32'(infer_cnt), 0);
        chk_img("rst_img");

        // continuous A5 image, exact settle latency
        send_image(0, 0, 8'hA5, 1'b0);
        chk("settle_in_ready", 32'(in_ready), 0);
        chk("settle_busy", 32'(busy), 1);
        for (int c = 1; c <= 3; c++) begin
            chk("settle_cv_low", 32'(class_valid), 0);
            step();
        end
        chk("settle_cv_low3", 32'(class_valid), 0);
        step();
        chk("latency_cv", 32'(class_valid), 1);
        chk("a5_class", 32'(class_out), 7);
        chk("a5_err", 32'(class_err), 0);
        chk("a5_infer", 32'(infer_cnt), 1);
        chk("a5_low_byte", 32'(img_out[7:0]), 32'hA5);
        chk("a5_top_nibble", 32'(img_out[899:896]), 32'h5);
        chk_img("a5_img");

        // backpressure in RESULT
        net_class = 4'd3;
        for (int c = 0; c < 20; c++) step();
        chk("bp_class_hold", 32'(class_out), 7);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_cv", 32'(class_valid), 1);
        release_result();
        chk("rel_in_ready", 32'(in_ready), 1);
        chk("rel_cv", 32'(class_valid), 0);
        chk("rel_busy", 32'(busy), 0);

        // gapped stream, beat k carries k
        net_class = 4'd2;
        send_image(0, 1, 8'h00, 1'b1);
        wait_valid("gap_valid");
        for (int k = 0; k < 112; k++) chk("gap_byte", 32'(img_out[k * 8 +: 8]), 32'(k));
        chk("gap_top_nibble", 32'(img_out[899:896]), 0);
        chk_img("gap_img");
        chk("gap_class", 32'(class_out), 2);
        chk("gap_infer", 32'(infer_cnt), 2);
        release_result();

        // flush together with beat 60
        for (int k = 0; k < 60; k++) send_beat(k, 8'hC0 ^ 8'(k), 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_img("flush_beat60_img");
        chk("flush_in_ready", 32'(in_ready), 1);
        send_beat(0, 8'h3C, 1'b0);
        in_valid = 1'b0;
        chk("flush_restart_byte0", 32'(img_out[7:0]), 32'h3C);
        chk_img("flush_restart_img");

        // flush during SETTLE
        net_class = 4'd9;
        send_image(1, 1, 8'h00, 1'b0);
        chk("pre_flush_busy", 32'(busy), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sflush_in_ready", 32'(in_ready), 1);
        chk("sflush_busy", 32'(busy), 0);
        for (int c = 0; c < 6; c++) step();
        chk("sflush_cv", 32'(class_valid), 0);
        chk("sflush_infer", 32'(infer_cnt), 2);
        chk("sflush_class", 32'(class_out), 2);
        chk_img("sflush_img");

        // out-of-range class index
        net_class = 4'd12;
        send_image(0, 0, 8'hFF, 1'b0);
        wait_valid("err_valid");
        chk("err_class", 32'(class_out), 12);
        chk("err_flag", 32'(class_err), 1);
        chk("err_infer", 32'(infer_cnt), 3);
        release_result();

        // counter wrap over 256 inferences from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_img = '0;
        net_class = 4'd5;
        class_ready = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            send_image(0, 0, 8'(n), 1'b0);
            wait_valid("wrap_valid");
            if (n == 255) chk("wrap_255", 32'(infer_cnt), 255);
            step();
        end
        chk("wrap_zero", 32'(infer_cnt), 0);
        send_image(0, 0, 8'h11, 1'b0);
        wait_valid("post_wrap_valid");
        chk("post_wrap_infer", 32'(infer_cnt), 1);
        chk("post_wrap_class", 32'(class_out), 5);
        step();
        class_ready = 1'b0;

        // reset mid-LOAD
        for (int k = 0; k < 50; k++) send_beat(k, 8'h77, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        exp_img = '0;
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_cv", 32'(class_valid), 0);
        chk("mid_rst_class", 32'(class_out), 0);
        chk("mid_rst_err", 32'(class_err), 0);
        chk("mid_rst_infer", 32'(infer_cnt), 0);
        chk_img("mid_rst_img");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
